// File: rtl/mppt_pkg.sv
// Shared definitions for the I2C register target: FSM state encoding and
// the default bus address.
package mppt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } i2c_state_t;

  localparam logic [6:0] DEFAULT_I2C_ADDR = 7'h50;

endpackage

// File: rtl/i2c_line_filter.sv
// 2-flop synchronizer for one I2C pad line, optionally followed by a
// 3-cycle stable-value glitch filter (I2C_TGT_GLITCH_FILTER_EN).
module i2c_line_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_out
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], line_in};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] stable_cnt;
  logic       filt;

  // Output follows only after the synchronized value differs for 3 clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt       <= 1'b1;
      stable_cnt <= '0;
    end else if (sync[1] == filt) begin
      stable_cnt <= '0;
    end else if (stable_cnt == 2'd2) begin
      filt       <= sync[1];
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 2'd1;
    end
  end

  assign line_out = filt;
`else
  assign line_out = sync[1];
`endif

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing an 8-bit register pointer interface (write pointer,
// burst write, burst read). Optional input filter: I2C_TGT_GLITCH_FILTER_EN.
module i2c_reg_target #(
  parameter logic [6:0]  I2C_ADDR = mppt_pkg::DEFAULT_I2C_ADDR,
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl_in,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       reg_re,
  output logic       busy
);
  import mppt_pkg::*;

  if (CLK_FREQ == 0) begin : g_clk_freq_check
    $error("i2c_reg_target: CLK_FREQ must be non-zero");
  end

  logic scl, sda, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  i2c_line_filter u_scl_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (i2c_scl_in),
    .line_out (scl)
  );

  i2c_line_filter u_sda_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (i2c_sda_in),
    .line_out (sda)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

  i2c_state_t state, state_next;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [6:0] tx;
  logic       ack_bit;
  logic       byte_done, shifting;
  logic       oe_next, cnt_clr, load_ptr, wr_go, rd_go, inc_addr;
  logic       busy_set, busy_clr, tx_shift;

  assign byte_done = (bit_cnt == 4'd8);
  assign shifting  = (state == ST_DEV_ADDR) || (state == ST_REG_PTR) ||
                     (state == ST_WR_DATA)  || (state == ST_RD_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // START/STOP override everything; all other moves happen on SCL fall.
  always_comb begin
    state_next = state;
    oe_next    = i2c_sda_oe;
    cnt_clr    = 1'b0;
    load_ptr   = 1'b0;
    wr_go      = 1'b0;
    rd_go      = 1'b0;
    inc_addr   = 1'b0;
    busy_set   = 1'b0;
    busy_clr   = 1'b0;
    tx_shift   = 1'b0;
    if (stop_det) begin
      state_next = ST_IDLE;
      oe_next    = 1'b0;
      busy_clr   = 1'b1;
    end else if (start_det) begin
      state_next = ST_DEV_ADDR;
      oe_next    = 1'b0;
      cnt_clr    = 1'b1;
    end else if (scl_fall) begin
      case (state)
        ST_DEV_ADDR: begin
          if (byte_done) begin
            if (shift[7:1] == I2C_ADDR && shift[7:1] != 7'd0) begin
              state_next = ST_DEV_ACK;
              oe_next    = 1'b1;
              busy_set   = 1'b1;
            end else begin
              state_next = ST_IDLE;
              busy_clr   = 1'b1;
            end
          end
        end
        ST_DEV_ACK: begin
          oe_next = 1'b0;
          cnt_clr = 1'b1;
          if (shift[0]) begin
            state_next = ST_RD_DATA;
            rd_go      = 1'b1;
          end else begin
            state_next = ST_REG_PTR;
          end
        end
        ST_REG_PTR: begin
          if (byte_done) begin
            state_next = ST_PTR_ACK;
            load_ptr   = 1'b1;
            oe_next    = 1'b1;
          end
        end
        ST_PTR_ACK: begin
          state_next = ST_WR_DATA;
          oe_next    = 1'b0;
          cnt_clr    = 1'b1;
        end
        ST_WR_DATA: begin
          if (byte_done) begin
            state_next = ST_WR_ACK;
            wr_go      = 1'b1;
            oe_next    = 1'b1;
          end
        end
        ST_WR_ACK: begin
          state_next = ST_WR_DATA;
          inc_addr   = 1'b1;
          oe_next    = 1'b0;
          cnt_clr    = 1'b1;
        end
        ST_RD_DATA: begin
          if (byte_done) begin
            state_next = ST_RD_ACK;
            oe_next    = 1'b0;
          end else begin
            tx_shift = 1'b1;
            oe_next  = ~tx[6];
          end
        end
        ST_RD_ACK: begin
          oe_next = 1'b0;
          cnt_clr = 1'b1;
          if (!ack_bit) begin
            state_next = ST_RD_DATA;
            inc_addr   = 1'b1;
            rd_go      = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shift      <= '0;
      tx         <= '0;
      ack_bit    <= 1'b1;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      busy       <= 1'b0;
      i2c_sda_oe <= 1'b0;
    end else begin
      reg_we     <= wr_go;
      reg_re     <= rd_go;
      i2c_sda_oe <= oe_next;
      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (scl_rise && shifting && !byte_done) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (state != ST_RD_DATA) shift <= {shift[6:0], sda};
      end
      if (scl_rise && state == ST_RD_ACK) ack_bit <= sda;
      if (load_ptr) begin
        reg_addr <= shift;
      end else if (inc_addr) begin
        reg_addr <= reg_addr + 8'd1;
      end
      if (wr_go) reg_wdata <= shift;
      if (tx_shift) tx <= {tx[5:0], 1'b0};
      // reg_re is registered, so reg_addr already points at the byte to send.
      if (reg_re && state_next == ST_RD_DATA) begin
        tx         <= reg_rdata[6:0];
        i2c_sda_oe <= ~reg_rdata[7];
      end
      if (busy_set) begin
        busy <= 1'b1;
      end else if (busy_clr) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Randomized scoreboard bench for i2c_reg_target: bit-banged host, register
// file model, strobe monitor popping expected events from a queue.
module tb_i2c_reg_target;

  localparam logic [6:0] ADDR = 7'h50;

  typedef struct packed {
    logic [1:0] kind;   // 2'b10 write strobe, 2'b01 read strobe
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk, rst_n;
  logic       scl_drv, sda_drv, sda_bus;
  logic       i2c_sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  int vectors = 0;
  int miscompares = 0;
  int ph = 50;
  ev_t exp_q[$];
  logic [7:0] model_mem [256];
  logic [7:0] mptr;
  logic [7:0] wbuf [4];
  logic ack_busy;

  bit [7:0] rf_mem [256];
  bit       rf_written [256];

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 8'h3C;
      8'h11:   return 8'h5A;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  assign sda_bus   = sda_drv & ~i2c_sda_oe;
  assign reg_rdata = rf_written[reg_addr] ? rf_mem[reg_addr] : init_val(reg_addr);

  always @(posedge clk) begin
    if (reg_we) begin
      rf_mem[reg_addr]     <= reg_wdata;
      rf_written[reg_addr] <= 1'b1;
    end
  end

  i2c_reg_target #(.I2C_ADDR(ADDR), .CLK_FREQ(50_000_000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i2c_scl_in (scl_drv),
    .i2c_sda_in (sda_bus),
    .i2c_sda_oe (i2c_sda_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_rdata  (reg_rdata),
    .reg_re     (reg_re),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    ev_t e;
    if (reg_we && reg_re) check("we_re_exclusive", 1, 0);
    if (reg_we || reg_re) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {reg_we, reg_re}, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {reg_we, reg_re}, e.kind);
        check("strobe_addr", reg_addr, e.addr);
        if (reg_we) check("strobe_wdata", reg_wdata, e.data);
      end
    end
  end

  task automatic i2c_start();
    sda_drv = 1'b1; #(ph);
    scl_drv = 1'b1; #(ph);
    sda_drv = 1'b0; #(ph);
    scl_drv = 1'b0; #(ph);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; #(ph);
    scl_drv = 1'b1; #(ph);
    sda_drv = 1'b1; #(ph);
  endtask

  task automatic send(input logic [7:0] b, input bit rst_ack, input bit glitch,
                      output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = b[i]; #(ph);
      scl_drv = 1'b1;
      if (glitch && i == 3) begin
        #(ph/2); scl_drv = 1'b0; #40; scl_drv = 1'b1; #(ph/2);
      end else begin
        #(ph);
      end
      scl_drv = 1'b0;
    end
    sda_drv = 1'b1; #(ph);
    scl_drv = 1'b1; #(ph/2);
    ack = sda_bus;
    ack_busy = busy;
    if (rst_ack) begin
      check("oe_before_reset", i2c_sda_oe, 1);
      rst_n = 1'b0;
      #1;
      check("oe_async_reset", i2c_sda_oe, 0);
      check("busy_async_reset", busy, 0);
    end
    #(ph/2); scl_drv = 1'b0;
  endtask

  task automatic recv(input bit nack, output logic [7:0] b);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #(ph); scl_drv = 1'b1;
      #(ph/2); b[i] = sda_bus;
      #(ph/2); scl_drv = 1'b0;
    end
    sda_drv = nack; #(ph);
    scl_drv = 1'b1; #(ph);
    scl_drv = 1'b0;
  endtask

  task automatic txn_write(input logic [6:0] a, input logic [7:0] p, input int n,
                           input bit glitch);
    logic ack;
    bit   hit;
    hit = (a == ADDR);
    i2c_start();
    send({a, 1'b0}, 1'b0, 1'b0, ack);
    check("addr_ack", ack, hit ? 0 : 1);
    check("busy_at_addr_ack", ack_busy, hit ? 1 : 0);
    if (hit) begin
      send(p, 1'b0, 1'b0, ack);
      check("ptr_ack", ack, 0);
      mptr = p;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{kind: 2'b10, addr: mptr, data: wbuf[i]});
        model_mem[mptr] = wbuf[i];
        send(wbuf[i], 1'b0, glitch, ack);
        check("data_ack", ack, 0);
        mptr = mptr + 8'd1;
      end
    end
    i2c_stop();
    #(ph);
    check("busy_after_stop", busy, 0);
    check("reg_addr_after_write", reg_addr, mptr);
  endtask

  task automatic txn_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] b;
    bit         last;
    i2c_start();
    if (set_ptr) begin
      send({ADDR, 1'b0}, 1'b0, 1'b0, ack);
      check("rd_addr_w_ack", ack, 0);
      send(p, 1'b0, 1'b0, ack);
      check("rd_ptr_ack", ack, 0);
      mptr = p;
      i2c_start();
    end
    exp_q.push_back('{kind: 2'b01, addr: mptr, data: 8'h00});
    send({ADDR, 1'b1}, 1'b0, 1'b0, ack);
    check("rd_addr_r_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      if (!last) exp_q.push_back('{kind: 2'b01, addr: mptr + 8'd1, data: 8'h00});
      recv(last, b);
      check("rd_byte", b, model_mem[mptr]);
      if (!last) mptr = mptr + 8'd1;
    end
    i2c_stop();
    #(ph);
    check("busy_after_read", busy, 0);
    check("reg_addr_after_read", reg_addr, mptr);
  endtask

  initial begin
    logic ack;
    int   k, n;
    logic [6:0] a;
    rst_n   = 1'b0;
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    mptr    = 8'h00;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));
    #95;
    check("rst_sda_oe", i2c_sda_oe, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_re", reg_re, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #200;

    ph = 1000;
    wbuf[0] = 8'h01;
    txn_write(ADDR, 8'h00, 1, 1'b0);
    txn_write(7'h51, 8'h00, 1, 1'b0);
    txn_read(1'b1, 8'h10, 2);
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    txn_write(ADDR, 8'hFF, 2, 1'b0);
    txn_write(7'h00, 8'h00, 1, 1'b0);

    // Reset asserted while the target acknowledges the pointer byte.
    i2c_start();
    send({ADDR, 1'b0}, 1'b0, 1'b0, ack);
    check("rst_test_addr_ack", ack, 0);
    send(8'h00, 1'b1, 1'b0, ack);
    #(ph);
    rst_n = 1'b1;
    mptr  = 8'h00;
    i2c_stop();
    check("reg_addr_after_reset", reg_addr, 0);
    wbuf[0] = 8'h77;
    txn_write(ADDR, 8'h00, 1, 1'b0);

    ph = 400;
`ifdef I2C_TGT_GLITCH_FILTER_EN
    wbuf[0] = 8'hC3;
    txn_write(ADDR, 8'h20, 1, 1'b1);
`endif
    for (int t = 0; t < 10; t++) begin
      k = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      case (k)
        0: begin
          for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
          txn_write(ADDR, ($urandom_range(0, 1) != 0) ? 8'($urandom_range(254, 255))
                                                     : 8'($urandom), n, 1'b0);
        end
        1: txn_read(1'b1, 8'($urandom), n);
        2: txn_read(1'b0, 8'h00, n);
        default: begin
          a = 7'($urandom);
          if (a == ADDR) a = a ^ 7'h01;
          wbuf[0] = 8'($urandom);
          txn_write(a, 8'($urandom), 1, 1'b0);
        end
      endcase
    end

    #(4 * ph);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_reg_target.md
I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h50, 7-bit target address matched on the bus.
REQ-002 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz (documentation; no timing derived from it).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i2c_scl_in  input  1  raw SCL from pad.
REQ-006 SHALL have port i2c_sda_in  input  1  raw SDA from pad.
REQ-007 SHALL have port i2c_sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 SHALL have port reg_addr  output  8  register pointer presented to the register file.
REQ-009 SHALL have port reg_wdata  output  8  write data.
REQ-010 SHALL have port reg_we  output  1  one-cycle write strobe.
REQ-011 SHALL have port reg_rdata  input  8  read data for reg_addr, valid same cycle.
REQ-012 SHALL have port reg_re  output  1  one-cycle strobe; byte at reg_addr is captured for transmission.
REQ-013 SHALL have port busy  output  1  high from START through STOP of a transaction addressed to this target.

Function
REQ-014 SCL/SDA SHALL pass through 2-flop synchronizers; edges and START/STOP SHALL be detected on synchronized signals only.
REQ-015 START = SDA fall while SCL high; STOP = SDA rise while SCL high; both SHALL be detected in any state, including mid-byte.
REQ-016 States: IDLE, DEV_ADDR, DEV_ACK, REG_PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-017 START from any state -> DEV_ADDR (repeated start keeps reg_addr); STOP from any state -> IDLE, SDA released.
REQ-018 Bits SHALL be sampled on SCL rising edge, MSB first; SDA drive changes only after SCL falling edge.
REQ-019 DEV_ADDR: after 8 bits, address match -> DEV_ACK (SDA low for 9th clock); mismatch -> IDLE, no ACK, no strobes.
REQ-020 DEV_ACK: R/W=0 -> REG_PTR; R/W=1 -> reg_re pulse, then RD_DATA.
REQ-021 REG_PTR: 8th bit loads reg_addr, then ACK; next state WR_DATA.
REQ-022 WR_DATA: 8th bit drives reg_wdata, one-cycle reg_we at current reg_addr, ACK, then reg_addr += 1.
REQ-023 RD_DATA: shift out captured byte; RD_ACK samples host ACK: ACK(0) -> reg_addr += 1, reg_re, next byte; NACK(1) -> release SDA, wait for STOP/START.
REQ-024 reg_addr SHALL wrap 8'hFF -> 8'h00 modulo 256.
REQ-025 General call (address 0) SHALL be NACKed.
REQ-026 reg_we and reg_re SHALL never assert in the same cycle; each at most once per byte.

Reset
REQ-027 On rst_n low: state IDLE, i2c_sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, synchronizers to 1.
REQ-028 Reset mid-transfer SHALL release SDA immediately (asynchronous); after reset the block waits for a new START.

Configuration
REQ-029 With I2C_TGT_GLITCH_FILTER_EN defined: a 3-cycle stable-value filter follows the synchronizers; pulses shorter than 3 clk are rejected; edge latency grows by 3 clk.
REQ-030 Without I2C_TGT_GLITCH_FILTER_EN: no filter; synchronizer outputs feed edge detection directly.

Structure
REQ-031 State encoding enum and default address constant SHALL live in shared package mppt_pkg.
REQ-032 Synchronizer plus optional filter SHALL be sub-module i2c_line_filter, instantiated once per line.

Verification
REQ-033 START, 0xA0, 0x00, 0x01, STOP (1 us phases, 50 MHz clk) -> three ACKs; reg_we once with reg_addr=0x00, reg_wdata=0x01.
REQ-034 START, 0xA2 (address 0x51) -> no ACK on 9th clock; no strobes; busy stays 0.
REQ-035 Write pointer 0x10, repeated START, 0xA1, read 2 bytes (ACK, NACK) with reg_rdata=0x3C then 0x5A -> bytes 0x3C, 0x5A on SDA; reg_addr ends at 0x11.
REQ-036 Write pointer 0xFF, data 0xAA, 0xBB -> writes at 0xFF then 0x00.
REQ-037 rst_n low during ACK of 0x00 write -> i2c_sda_oe=0 same cycle; no reg_we; next full transaction succeeds.
REQ-038 With I2C_TGT_GLITCH_FILTER_EN: 2-clk SCL low glitch in WR_DATA -> bit count unchanged, byte written correctly.
